// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg
// Shared definitions for the rv32i pipeline: datapath width, load/store
// funct3 encodings, access-size codes, the MEM-stage FSM state type and a
// helper that classifies an access as misaligned.
// ---------------------------------------------------------------------------
package rv_pkg;

   localparam int XLEN = 32;

   // Load encodings (funct3)
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // Store encodings (funct3)
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   // Access size is funct3[1:0] for both loads and stores
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   typedef enum logic [1:0] {
      ST_RUN       = 2'b00,
      ST_WAIT_GNT  = 2'b01,
      ST_WAIT_DATA = 2'b10
   } mem_state_e;

   // An unknown size code is reported as misaligned so it never reaches memory.
   function automatic logic is_misaligned(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
      logic mis;
      case (size)
         SZ_B:    mis = 1'b0;
         SZ_H:    mis = addr_lo[0];
         SZ_W:    mis = (addr_lo != 2'b00);
         default: mis = 1'b1;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/rv_lsu_align.sv
// ---------------------------------------------------------------------------
// rv_lsu_align
// Combinational lane handling for the data memory port.
//   Store side: st_size/st_addr_lo/st_data -> st_strb (byte enables) and
//               st_wdata (store data replicated across the lanes).
//   Load side : ld_funct3/ld_addr_lo/ld_rdata -> ld_data (selected lane,
//               sign- or zero-extended to XLEN).
// ---------------------------------------------------------------------------
module rv_lsu_align
   import rv_pkg::*;
(
   input  logic [1:0]      st_size,
   input  logic [1:0]      st_addr_lo,
   input  logic [XLEN-1:0] st_data,
   output logic [3:0]      st_strb,
   output logic [XLEN-1:0] st_wdata,
   input  logic [2:0]      ld_funct3,
   input  logic [1:0]      ld_addr_lo,
   input  logic [XLEN-1:0] ld_rdata,
   output logic [XLEN-1:0] ld_data
);

   logic [XLEN-1:0] ld_shifted;

   // Store strobes and lane replication; aligned halves only use offsets 0/2.
   always_comb begin
      st_strb  = 4'b0000;
      st_wdata = {XLEN{1'b0}};
      case (st_size)
         SZ_B: begin
            st_strb  = 4'b0001 << st_addr_lo;
            st_wdata = {4{st_data[7:0]}};
         end
         SZ_H: begin
            st_strb  = 4'b0011 << st_addr_lo;
            st_wdata = {2{st_data[15:0]}};
         end
         SZ_W: begin
            st_strb  = 4'b1111;
            st_wdata = st_data;
         end
         default: begin
            st_strb  = 4'b0000;
            st_wdata = {XLEN{1'b0}};
         end
      endcase
   end

   // Bring the addressed lane down to bit 0 before extension.
   assign ld_shifted = ld_rdata >> {ld_addr_lo, 3'b000};

   // Load extension by funct3.
   always_comb begin
      ld_data = {XLEN{1'b0}};
      case (ld_funct3)
         F3_LB:   ld_data = {{(XLEN-8){ld_shifted[7]}}, ld_shifted[7:0]};
         F3_LH:   ld_data = {{(XLEN-16){ld_shifted[15]}}, ld_shifted[15:0]};
         F3_LW:   ld_data = ld_rdata;
         F3_LBU:  ld_data = {{(XLEN-8){1'b0}}, ld_shifted[7:0]};
         F3_LHU:  ld_data = {{(XLEN-16){1'b0}}, ld_shifted[15:0]};
         default: ld_data = ld_rdata;
      endcase
   end

endmodule

// File: rtl/rv_stage_mem.sv
// ---------------------------------------------------------------------------
// rv_stage_mem
// Memory-access stage of the rv32i pipeline. Issues loads/stores over a
// req/gnt + rvalid data-memory handshake, holds the MEM/WB register and
// stalls the pipeline while a grant or read data is outstanding.
//   EX/MEM in : i_mem_valid, i_mem_is_load/store, i_mem_funct3,
//               i_mem_alu_result, i_mem_store_data, i_mem_rf_wen/waddr
//   dmem      : o_dmem_req/we/addr/wstrb/wdata, i_dmem_gnt,
//               i_dmem_rvalid, i_dmem_rdata
//   to WB     : o_wb_is_load, o_wb_dmem_rdata, o_wb_rf_wen, o_wb_rf_waddr,
//               o_wb_rf_wdata_pre
//   control   : o_mem_rf_wdata_fwd, o_mem_stall, o_mem_misaligned
// ---------------------------------------------------------------------------
module rv_stage_mem
   import rv_pkg::*;
(
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_mem_valid,
   input  logic            i_mem_is_load,
   input  logic            i_mem_is_store,
   input  logic [2:0]      i_mem_funct3,
   input  logic [XLEN-1:0] i_mem_alu_result,
   input  logic [XLEN-1:0] i_mem_store_data,
   input  logic            i_mem_rf_wen,
   input  logic [4:0]      i_mem_rf_waddr,
   output logic            o_dmem_req,
   output logic            o_dmem_we,
   output logic [XLEN-1:0] o_dmem_addr,
   output logic [3:0]      o_dmem_wstrb,
   output logic [XLEN-1:0] o_dmem_wdata,
   input  logic            i_dmem_gnt,
   input  logic            i_dmem_rvalid,
   input  logic [XLEN-1:0] i_dmem_rdata,
   output logic            o_wb_is_load,
   output logic [XLEN-1:0] o_wb_dmem_rdata,
   output logic            o_wb_rf_wen,
   output logic [4:0]      o_wb_rf_waddr,
   output logic [XLEN-1:0] o_wb_rf_wdata_pre,
   output logic [XLEN-1:0] o_mem_rf_wdata_fwd,
   output logic            o_mem_stall,
   output logic            o_mem_misaligned
);

   mem_state_e state;
   mem_state_e next_state;

   // MEM/WB pipeline register
   logic            reg_is_load;
   logic            reg_rf_wen;
   logic [4:0]      reg_rf_waddr;
   logic [XLEN-1:0] reg_wdata_pre;
   logic [2:0]      reg_funct3;
   logic [1:0]      reg_addr_lo;

   logic            is_mem;
   logic            access_mis;
   logic            access_ok;
   logic            data_wait;
   logic            req;
   logic            stall;
   logic            advance;
   logic            bubble;
   logic            mis_flag;
   logic [3:0]      st_strb;
   logic [XLEN-1:0] st_wdata;
   logic [XLEN-1:0] ld_data;

   assign is_mem     = i_mem_valid & (i_mem_is_load | i_mem_is_store);
   assign access_mis = is_mem & is_misaligned(i_mem_funct3[1:0], i_mem_alu_result[1:0]);
   assign access_ok  = is_mem & ~access_mis;
   // A granted load sits in MEM/WB until its read data comes back.
   assign data_wait  = reg_is_load & ~i_dmem_rvalid;

   rv_lsu_align u_align (
      .st_size    (i_mem_funct3[1:0]),
      .st_addr_lo (i_mem_alu_result[1:0]),
      .st_data    (i_mem_store_data),
      .st_strb    (st_strb),
      .st_wdata   (st_wdata),
      .ld_funct3  (reg_funct3),
      .ld_addr_lo (reg_addr_lo),
      .ld_rdata   (i_dmem_rdata),
      .ld_data    (ld_data)
   );

   // FSM state register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= ST_RUN;
      end else begin
         state <= next_state;
      end
   end

   // Next state, request and pipeline control. WAIT_DATA shares RUN's
   // logic so a new request can issue in the cycle the read data returns.
   always_comb begin
      next_state = state;
      req        = 1'b0;
      stall      = 1'b0;
      advance    = 1'b0;
      bubble     = 1'b0;
      mis_flag   = 1'b0;
      case (state)
         ST_RUN, ST_WAIT_DATA, ST_WAIT_GNT: begin
            if (data_wait) begin
               // MEM/WB frozen, nothing issued while a load is outstanding
               stall      = 1'b1;
               next_state = ST_WAIT_DATA;
            end else if (access_ok) begin
               req = 1'b1;
               if (i_dmem_gnt) begin
                  advance    = 1'b1;
                  next_state = ST_RUN;
               end else begin
                  stall      = 1'b1;
                  bubble     = 1'b1;
                  next_state = ST_WAIT_GNT;
               end
            end else begin
               // non-memory op, misaligned access or empty slot
               advance    = 1'b1;
               mis_flag   = access_mis;
               next_state = ST_RUN;
            end
         end
         default: begin
            bubble     = 1'b1;
            next_state = ST_RUN;
         end
      endcase
   end

   // MEM/WB register: capture on advance, insert bubble, otherwise hold.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         reg_is_load   <= 1'b0;
         reg_rf_wen    <= 1'b0;
         reg_rf_waddr  <= 5'd0;
         reg_wdata_pre <= {XLEN{1'b0}};
         reg_funct3    <= 3'd0;
         reg_addr_lo   <= 2'd0;
      end else if (advance) begin
         reg_is_load   <= access_ok & i_mem_is_load;
         reg_rf_wen    <= i_mem_valid & i_mem_rf_wen & ~access_mis;
         reg_rf_waddr  <= i_mem_rf_waddr;
         reg_wdata_pre <= i_mem_alu_result;
         reg_funct3    <= i_mem_funct3;
         reg_addr_lo   <= i_mem_alu_result[1:0];
      end else if (bubble) begin
         reg_is_load   <= 1'b0;
         reg_rf_wen    <= 1'b0;
         reg_rf_waddr  <= 5'd0;
         reg_wdata_pre <= {XLEN{1'b0}};
         reg_funct3    <= 3'd0;
         reg_addr_lo   <= 2'd0;
      end else begin
         reg_is_load   <= reg_is_load;
         reg_rf_wen    <= reg_rf_wen;
         reg_rf_waddr  <= reg_rf_waddr;
         reg_wdata_pre <= reg_wdata_pre;
         reg_funct3    <= reg_funct3;
         reg_addr_lo   <= reg_addr_lo;
      end
   end

   // Output drive; everything reads as zero while reset is held.
   always_comb begin
      o_dmem_req         = 1'b0;
      o_dmem_we          = 1'b0;
      o_dmem_addr        = {XLEN{1'b0}};
      o_dmem_wstrb       = 4'b0000;
      o_dmem_wdata       = {XLEN{1'b0}};
      o_wb_is_load       = 1'b0;
      o_wb_dmem_rdata    = {XLEN{1'b0}};
      o_wb_rf_wen        = 1'b0;
      o_wb_rf_waddr      = 5'd0;
      o_wb_rf_wdata_pre  = {XLEN{1'b0}};
      o_mem_rf_wdata_fwd = {XLEN{1'b0}};
      o_mem_stall        = 1'b0;
      o_mem_misaligned   = 1'b0;
      if (!i_rst) begin
         o_dmem_req         = req;
         o_dmem_we          = req & i_mem_is_store;
         o_dmem_addr        = req ? {i_mem_alu_result[XLEN-1:2], 2'b00} : {XLEN{1'b0}};
         o_dmem_wstrb       = (req & i_mem_is_store) ? st_strb : 4'b0000;
         o_dmem_wdata       = (req & i_mem_is_store) ? st_wdata : {XLEN{1'b0}};
         o_wb_is_load       = reg_is_load;
         o_wb_dmem_rdata    = ld_data;
         // a load only writes back in the cycle its data arrives
         o_wb_rf_wen        = reg_rf_wen & (~reg_is_load | i_dmem_rvalid);
         o_wb_rf_waddr      = reg_rf_waddr;
         o_wb_rf_wdata_pre  = reg_wdata_pre;
         o_mem_rf_wdata_fwd = i_mem_alu_result;
         o_mem_stall        = stall;
         o_mem_misaligned   = mis_flag;
      end else begin
         o_mem_stall        = 1'b0;
      end
   end

endmodule

// File: tb/tb_rv_stage_mem.sv
// ---------------------------------------------------------------------------
// tb_rv_stage_mem
// Self-checking bench for rv_stage_mem: a table of single-access vectors
// (request cycle + writeback cycle) followed by hand-written sequences for
// grant stalls, delayed read data and reset during a pending load.
// ---------------------------------------------------------------------------
module tb_rv_stage_mem;
   import rv_pkg::*;

   logic            clk = 1'b0;
   logic            rst;
   logic            mem_valid, mem_is_load, mem_is_store;
   logic [2:0]      mem_funct3;
   logic [31:0]     mem_alu_result, mem_store_data;
   logic            mem_rf_wen;
   logic [4:0]      mem_rf_waddr;
   logic            dmem_req, dmem_we;
   logic [31:0]     dmem_addr, dmem_wdata;
   logic [3:0]      dmem_wstrb;
   logic            dmem_gnt, dmem_rvalid;
   logic [31:0]     dmem_rdata;
   logic            wb_is_load, wb_rf_wen;
   logic [31:0]     wb_dmem_rdata, wb_rf_wdata_pre, mem_rf_wdata_fwd;
   logic [4:0]      wb_rf_waddr;
   logic            mem_stall, mem_misaligned;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   rv_stage_mem dut (
      .i_clk              (clk),
      .i_rst              (rst),
      .i_mem_valid        (mem_valid),
      .i_mem_is_load      (mem_is_load),
      .i_mem_is_store     (mem_is_store),
      .i_mem_funct3       (mem_funct3),
      .i_mem_alu_result   (mem_alu_result),
      .i_mem_store_data   (mem_store_data),
      .i_mem_rf_wen       (mem_rf_wen),
      .i_mem_rf_waddr     (mem_rf_waddr),
      .o_dmem_req         (dmem_req),
      .o_dmem_we          (dmem_we),
      .o_dmem_addr        (dmem_addr),
      .o_dmem_wstrb       (dmem_wstrb),
      .o_dmem_wdata       (dmem_wdata),
      .i_dmem_gnt         (dmem_gnt),
      .i_dmem_rvalid      (dmem_rvalid),
      .i_dmem_rdata       (dmem_rdata),
      .o_wb_is_load       (wb_is_load),
      .o_wb_dmem_rdata    (wb_dmem_rdata),
      .o_wb_rf_wen        (wb_rf_wen),
      .o_wb_rf_waddr      (wb_rf_waddr),
      .o_wb_rf_wdata_pre  (wb_rf_wdata_pre),
      .o_mem_rf_wdata_fwd (mem_rf_wdata_fwd),
      .o_mem_stall        (mem_stall),
      .o_mem_misaligned   (mem_misaligned)
   );

   typedef struct {
      logic        ld;
      logic        st;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] sdata;
      logic        rf_wen;
      logic [31:0] rdata;
      logic        e_req;
      logic        e_we;
      logic [31:0] e_daddr;
      logic [3:0]  e_strb;
      logic [31:0] e_wdata;
      logic        e_mis;
      logic        e_wb_wen;
      logic        e_wb_load;
      logic [31:0] e_wb_rdata;
   } vec_t;

   vec_t vecs[13];

   function automatic vec_t mk(logic ld, logic st, logic [2:0] f3, logic [31:0] addr,
                               logic [31:0] sdata, logic rf_wen, logic [31:0] rdata,
                               logic e_req, logic e_we, logic [31:0] e_daddr,
                               logic [3:0] e_strb, logic [31:0] e_wdata, logic e_mis,
                               logic e_wb_wen, logic e_wb_load, logic [31:0] e_wb_rdata);
      vec_t v;
      v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.sdata = sdata;
      v.rf_wen = rf_wen; v.rdata = rdata; v.e_req = e_req; v.e_we = e_we;
      v.e_daddr = e_daddr; v.e_strb = e_strb; v.e_wdata = e_wdata; v.e_mis = e_mis;
      v.e_wb_wen = e_wb_wen; v.e_wb_load = e_wb_load; v.e_wb_rdata = e_wb_rdata;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_instr(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] sdata,
                            input logic wen, input logic [4:0] waddr);
      mem_valid = v; mem_is_load = ld; mem_is_store = st; mem_funct3 = f3;
      mem_alu_result = addr; mem_store_data = sdata; mem_rf_wen = wen; mem_rf_waddr = waddr;
   endtask

   task automatic set_mem(input logic gnt, input logic rv, input logic [31:0] rd);
      dmem_gnt = gnt; dmem_rvalid = rv; dmem_rdata = rd;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // SB / LB / LBU / SH / SW / LH / LHU / LW / ALU / misaligned SH, LW / LB / SB
      vecs[0]  = mk(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 1'b0, 32'h0,
                    1'b1, 1'b1, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB, 1'b0, 1'b0, 1'b0, 32'h0);
      vecs[1]  = mk(1'b1, 1'b0, 3'b000, 32'h0000_2001, 32'h0, 1'b1, 32'h0000_8000,
                    1'b1, 1'b0, 32'h0000_2000, 4'b0000, 32'h0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FF80);
      vecs[2]  = mk(1'b1, 1'b0, 3'b100, 32'h0000_2001, 32'h0, 1'b1, 32'h0000_8000,
                    1'b1, 1'b0, 32'h0000_2000, 4'b0000, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0080);
      vecs[3]  = mk(1'b0, 1'b1, 3'b001, 32'h0000_3002, 32'h1234_BEEF, 1'b0, 32'h0,
                    1'b1, 1'b1, 32'h0000_3000, 4'b1100, 32'hBEEF_BEEF, 1'b0, 1'b0, 1'b0, 32'h0);
      vecs[4]  = mk(1'b0, 1'b1, 3'b010, 32'h0000_4000, 32'hDEAD_BEEF, 1'b0, 32'h0,
                    1'b1, 1'b1, 32'h0000_4000, 4'b1111, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h0);
      vecs[5]  = mk(1'b1, 1'b0, 3'b001, 32'h0000_5002, 32'h0, 1'b1, 32'h8001_1234,
                    1'b1, 1'b0, 32'h0000_5000, 4'b0000, 32'h0, 1'b0, 1'b1, 1'b1, 32'hFFFF_8001);
      vecs[6]  = mk(1'b1, 1'b0, 3'b101, 32'h0000_5002, 32'h0, 1'b1, 32'h8001_1234,
                    1'b1, 1'b0, 32'h0000_5000, 4'b0000, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_8001);
      vecs[7]  = mk(1'b1, 1'b0, 3'b010, 32'h0000_6004, 32'h0, 1'b1, 32'hCAFE_F00D,
                    1'b1, 1'b0, 32'h0000_6004, 4'b0000, 32'h0, 1'b0, 1'b1, 1'b1, 32'hCAFE_F00D);
      vecs[8]  = mk(1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0, 1'b1, 32'h0,
                    1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
      vecs[9]  = mk(1'b0, 1'b1, 3'b001, 32'h0000_3001, 32'h0000_5A5A, 1'b1, 32'h0,
                    1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
      vecs[10] = mk(1'b1, 1'b0, 3'b010, 32'h0000_6002, 32'h0, 1'b1, 32'h0,
                    1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
      vecs[11] = mk(1'b1, 1'b0, 3'b000, 32'h0000_2003, 32'h0, 1'b1, 32'h7F00_0000,
                    1'b1, 1'b0, 32'h0000_2000, 4'b0000, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_007F);
      vecs[12] = mk(1'b0, 1'b1, 3'b000, 32'h0000_1001, 32'h0000_0055, 1'b0, 32'h0,
                    1'b1, 1'b1, 32'h0000_1000, 4'b0010, 32'h5555_5555, 1'b0, 1'b0, 1'b0, 32'h0);

      // ---------------- reset state ----------------
      rst = 1'b1;
      set_instr(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 1'b1, 5'd1);
      set_mem(1'b0, 1'b0, 32'h0);
      next_cycle();
      next_cycle();
      @(negedge clk);
      chk("rst_req", {31'd0, dmem_req}, 32'd0);
      chk("rst_stall", {31'd0, mem_stall}, 32'd0);
      chk("rst_wb_wen", {31'd0, wb_rf_wen}, 32'd0);
      chk("rst_wb_load", {31'd0, wb_is_load}, 32'd0);
      chk("rst_mis", {31'd0, mem_misaligned}, 32'd0);
      next_cycle();
      rst = 1'b0;
      set_instr(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 5'd0);

      // ---------------- table vectors ----------------
      for (int i = 0; i < 13; i++) begin
         next_cycle();
         set_instr(1'b1, vecs[i].ld, vecs[i].st, vecs[i].f3, vecs[i].addr,
                   vecs[i].sdata, vecs[i].rf_wen, 5'(i + 1));
         set_mem(1'b1, 1'b0, 32'h0);
         @(negedge clk);
         chk($sformatf("v%0d_req", i), {31'd0, dmem_req}, {31'd0, vecs[i].e_req});
         chk($sformatf("v%0d_we", i), {31'd0, dmem_we}, {31'd0, vecs[i].e_we});
         chk($sformatf("v%0d_addr", i), dmem_addr, vecs[i].e_daddr);
         chk($sformatf("v%0d_strb", i), {28'd0, dmem_wstrb}, {28'd0, vecs[i].e_strb});
         chk($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].e_wdata);
         chk($sformatf("v%0d_stall", i), {31'd0, mem_stall}, 32'd0);
         chk($sformatf("v%0d_mis", i), {31'd0, mem_misaligned}, {31'd0, vecs[i].e_mis});
         chk($sformatf("v%0d_fwd", i), mem_rf_wdata_fwd, vecs[i].addr);

         next_cycle();
         set_instr(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 5'd0);
         set_mem(1'b0, vecs[i].e_wb_load, vecs[i].e_wb_load ? vecs[i].rdata : 32'hDEAD_0000);
         @(negedge clk);
         chk($sformatf("v%0d_wb_wen", i), {31'd0, wb_rf_wen}, {31'd0, vecs[i].e_wb_wen});
         chk($sformatf("v%0d_wb_load", i), {31'd0, wb_is_load}, {31'd0, vecs[i].e_wb_load});
         chk($sformatf("v%0d_wb_stall", i), {31'd0, mem_stall}, 32'd0);
         chk($sformatf("v%0d_wb_mis", i), {31'd0, mem_misaligned}, 32'd0);
         if (vecs[i].e_wb_wen) begin
            chk($sformatf("v%0d_wb_waddr", i), {27'd0, wb_rf_waddr}, 32'(i + 1));
            chk($sformatf("v%0d_wb_pre", i), wb_rf_wdata_pre, vecs[i].addr);
         end
         if (vecs[i].e_wb_load) begin
            chk($sformatf("v%0d_wb_rdata", i), wb_dmem_rdata, vecs[i].e_wb_rdata);
         end
      end

      // ---------------- LW with grant withheld for 3 cycles ----------------
      next_cycle();
      set_instr(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_7000, 32'h0, 1'b1, 5'd20);
      for (int c = 0; c < 3; c++) begin
         set_mem(1'b0, 1'b0, 32'h0);
         @(negedge clk);
         chk($sformatf("gnt_wait%0d_stall", c), {31'd0, mem_stall}, 32'd1);
         chk($sformatf("gnt_wait%0d_req", c), {31'd0, dmem_req}, 32'd1);
         chk($sformatf("gnt_wait%0d_addr", c), dmem_addr, 32'h0000_7000);
         if (c > 0) begin
            chk($sformatf("gnt_wait%0d_wb_wen", c), {31'd0, wb_rf_wen}, 32'd0);
            chk($sformatf("gnt_wait%0d_wb_load", c), {31'd0, wb_is_load}, 32'd0);
         end
         next_cycle();
      end
      set_mem(1'b1, 1'b0, 32'h0);
      @(negedge clk);
      chk("gnt_ok_stall", {31'd0, mem_stall}, 32'd0);
      chk("gnt_ok_req", {31'd0, dmem_req}, 32'd1);
      chk("gnt_ok_wb_load", {31'd0, wb_is_load}, 32'd0);
      next_cycle();
      set_instr(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 5'd0);
      set_mem(1'b0, 1'b1, 32'h1122_3344);
      @(negedge clk);
      chk("gnt_done_wb_wen", {31'd0, wb_rf_wen}, 32'd1);
      chk("gnt_done_waddr", {27'd0, wb_rf_waddr}, 32'd20);
      chk("gnt_done_rdata", wb_dmem_rdata, 32'h1122_3344);
      chk("gnt_done_stall", {31'd0, mem_stall}, 32'd0);

      // ---------------- LW with read data 2 cycles late, next LW waiting ----------------
      next_cycle();
      set_instr(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_7004, 32'h0, 1'b1, 5'd9);
      set_mem(1'b1, 1'b0, 32'h0);
      @(negedge clk);
      chk("late_issue_req", {31'd0, dmem_req}, 32'd1);
      next_cycle();
      set_instr(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_8000, 32'h0, 1'b1, 5'd10);
      for (int c = 0; c < 2; c++) begin
         set_mem(1'b1, 1'b0, 32'h0);
         @(negedge clk);
         chk($sformatf("late%0d_stall", c), {31'd0, mem_stall}, 32'd1);
         chk($sformatf("late%0d_wb_wen", c), {31'd0, wb_rf_wen}, 32'd0);
         chk($sformatf("late%0d_req", c), {31'd0, dmem_req}, 32'd0);
         next_cycle();
      end
      set_mem(1'b1, 1'b1, 32'hA5A5_A5A5);
      @(negedge clk);
      chk("late_ret_stall", {31'd0, mem_stall}, 32'd0);
      chk("late_ret_wb_wen", {31'd0, wb_rf_wen}, 32'd1);
      chk("late_ret_waddr", {27'd0, wb_rf_waddr}, 32'd9);
      chk("late_ret_rdata", wb_dmem_rdata, 32'hA5A5_A5A5);
      chk("late_ret_req", {31'd0, dmem_req}, 32'd1);
      chk("late_ret_addr", dmem_addr, 32'h0000_8000);
      next_cycle();
      set_instr(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 5'd0);
      set_mem(1'b0, 1'b1, 32'h0102_0304);
      @(negedge clk);
      chk("back2back_wb_wen", {31'd0, wb_rf_wen}, 32'd1);
      chk("back2back_waddr", {27'd0, wb_rf_waddr}, 32'd10);
      chk("back2back_rdata", wb_dmem_rdata, 32'h0102_0304);

      // ---------------- reset while waiting for read data ----------------
      next_cycle();
      set_instr(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_9000, 32'h0, 1'b1, 5'd11);
      set_mem(1'b1, 1'b0, 32'h0);
      next_cycle();
      set_instr(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 5'd0);
      set_mem(1'b0, 1'b0, 32'h0);
      @(negedge clk);
      chk("rstw_pre_stall", {31'd0, mem_stall}, 32'd1);
      #2;
      rst = 1'b1;
      set_instr(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_9004, 32'h0, 1'b1, 5'd12);
      #1;
      chk("rstw_stall", {31'd0, mem_stall}, 32'd0);
      chk("rstw_req", {31'd0, dmem_req}, 32'd0);
      chk("rstw_wb_load", {31'd0, wb_is_load}, 32'd0);
      chk("rstw_wb_wen", {31'd0, wb_rf_wen}, 32'd0);
      next_cycle();
      rst = 1'b0;
      set_instr(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 5'd0);
      set_mem(1'b0, 1'b1, 32'hFFFF_FFFF);
      @(negedge clk);
      chk("rstw_late_wb_wen", {31'd0, wb_rf_wen}, 32'd0);
      chk("rstw_late_wb_load", {31'd0, wb_is_load}, 32'd0);
      chk("rstw_late_stall", {31'd0, mem_stall}, 32'd0);
      next_cycle();
      set_mem(1'b0, 1'b0, 32'h0);
      @(negedge clk);
      chk("rstw_idle_stall", {31'd0, mem_stall}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rv_stage_mem.md
# rv_stage_mem

Memory-access stage of the rv32i pipeline, between EX/MEM and the WB stage. Issues loads/stores to the data memory over a req/gnt + rvalid handshake, aligns store data and byte strobes, and holds the MEM/WB pipeline register. Produces sign/zero-extended load data for WB in the same cycle the memory returns it. Stalls the pipeline on missing grant or late read data, and flags misaligned accesses.

## Interface
- XLEN, 32, datapath width (from rv_pkg)
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-high reset
- i_mem_valid  in  1  EX/MEM holds a real instruction
- i_mem_is_load / i_mem_is_store  in  1  access type (mutually exclusive)
- i_mem_funct3  in  3  LB/LH/LW/LBU/LHU, SB/SH/SW encoding
- i_mem_alu_result  in  XLEN  effective address, or ALU result for non-memory ops
- i_mem_store_data  in  XLEN  rs2 value
- i_mem_rf_wen / i_mem_rf_waddr  in  1/5  destination write
- o_dmem_req  out  1  access request
- o_dmem_we  out  1  1=store
- o_dmem_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00})
- o_dmem_wstrb  out  4  byte enables
- o_dmem_wdata  out  XLEN  lane-replicated store data
- i_dmem_gnt  in  1  request accepted this cycle
- i_dmem_rvalid / i_dmem_rdata  in  1/XLEN  read data return
- o_wb_is_load, o_wb_dmem_rdata (extended), o_wb_rf_wen, o_wb_rf_waddr, o_wb_rf_wdata_pre  out  1/XLEN/1/5/XLEN  to WB stage
- o_mem_rf_wdata_fwd  out  XLEN  = i_mem_alu_result, forwarding to EX
- o_mem_stall  out  1  freeze IF..MEM
- o_mem_misaligned  out  1  single-cycle misalignment flag

## Operation
- FSM states RUN, WAIT_GNT, WAIT_DATA; reset to RUN.
- RUN: valid aligned load/store drives o_dmem_req. gnt=1 -> advance into MEM/WB (load sets pending). gnt=0 -> WAIT_GNT.
- WAIT_GNT: req, we, addr, wstrb, wdata held stable; o_mem_stall=1; MEM/WB loads a bubble each cycle; on gnt -> advance, RUN.
- WAIT_DATA: entered when MEM/WB holds a pending load and i_dmem_rvalid=0; o_mem_stall=1, MEM/WB frozen, no new request issued; on rvalid -> WB completes, RUN.
- At most one outstanding load. A new request may issue in the same cycle rvalid returns.
- o_wb_rf_wen = reg_rf_wen & (!reg_is_load | i_dmem_rvalid).
- Stores: SB wstrb=4'b0001<<addr[1:0], byte replicated x4. SH wstrb=4'b0011<<addr[1:0], half replicated x2. SW wstrb=4'b1111.
- Loads: o_wb_dmem_rdata extracts lane by registered addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0): no request, o_mem_misaligned=1 for one cycle, instruction advances as bubble (rf_wen=0), no stall.
- Non-memory ops: advance with o_wb_rf_wdata_pre=i_mem_alu_result, no request.

## Timing
- Zero-wait memory: request cycle N (gnt=1), rvalid cycle N+1 = WB cycle; no stall, load-to-use handled by the hazard unit.
- Store completes at gnt; it never enters WAIT_DATA.
- Simultaneous WAIT_DATA condition and ungranted MEM request: stall; MEM request held, not issued until pending load returns.
- Reset (any cycle, including mid-WAIT): all outputs 0, state RUN, pending load dropped; late rvalid after reset ignored.

## Structure
- rv_pkg: XLEN, funct3 localparams, mem_state_e enum.
- Sub-module rv_lsu_align: combinational store lane/strobe generation, load extraction/extension.
- rv_stage_mem holds FSM, MEM/WB register, handshake.

## Test plan
- SB addr=0x1003, data=0x000000AB, gnt=1 -> addr=0x1000, wstrb=4'b1000, wdata=0xABABABAB, no stall.
- LB addr=0x2001, rdata=0x0000_80_00 next cycle -> o_wb_dmem_rdata=0xFFFFFF80; LBU -> 0x00000080.
- LW with gnt low 3 cycles -> stall 3 cycles, request stable, 3 bubbles in WB, then normal.
- LW granted, rvalid delayed 2 cycles -> stall 2 cycles, o_wb_rf_wen only in rvalid cycle.
- SH addr=0x3001 -> no req, o_mem_misaligned pulse, o_wb_rf_wen=0, no stall.
- Reset asserted in WAIT_DATA -> outputs 0, state RUN, subsequent rvalid ignored.
